// File: rtl/brg_pkg.sv
// Shared constants, CSR layout and divisor lookup for the MC68681 channel baud-rate generator.
package brg_pkg;

    localparam int unsigned BRG_DIV_W  = 16;
    localparam int unsigned BRG_CLK_HZ = 3_686_400;

    localparam logic [3:0] BRG_EXT16   = 4'hE;
    localparam logic [3:0] BRG_OFF     = 4'hD;
    localparam logic [3:0] BRG_OFF_F   = 4'hF;
    localparam logic [7:0] BRG_CSR_RST = 8'hBB;

    typedef struct packed {
        logic [3:0] rx;
        logic [3:0] tx;
    } brg_csr_t;

    // Baud rate times ten so 134.5 baud stays integral; 0 marks off/ext codes.
    function automatic int unsigned brg_baud_x10(input logic [3:0] code, input logic set);
        int unsigned b;
        case (code)
            4'h0:    b = set ? 32'd750    : 32'd500;
            4'h1:    b = 32'd1100;
            4'h2:    b = 32'd1345;
            4'h3:    b = set ? 32'd1500   : 32'd2000;
            4'h4:    b = 32'd3000;
            4'h5:    b = 32'd6000;
            4'h6:    b = 32'd12000;
            4'h7:    b = set ? 32'd20000  : 32'd10500;
            4'h8:    b = 32'd24000;
            4'h9:    b = 32'd48000;
            4'hA:    b = set ? 32'd18000  : 32'd72000;
            4'hB:    b = 32'd96000;
            4'hC:    b = set ? 32'd192000 : 32'd384000;
            default: b = 32'd0;
        endcase
        return b;
    endfunction

    // round(clk_hz / (16 * baud)); 0 means no internal divider for this code.
    function automatic logic [BRG_DIV_W-1:0] brg_divisor(input logic [3:0] code, input logic set,
                                                         input int unsigned clk_hz);
        longint unsigned b10;
        longint unsigned num;
        longint unsigned den;
        b10 = 64'(brg_baud_x10(code, set));
        if (b10 == 64'd0) begin
            return '0;
        end
        num = 64'(clk_hz) * 64'd10 + 64'd8 * b10;
        den = 64'd16 * b10;
        return BRG_DIV_W'(num / den);
    endfunction

endpackage

// File: rtl/brg_div.sv
// One 16x enable generator: reloadable down-counter with change detect, or ext pulse pass-through.
module brg_div
    import brg_pkg::*;
#(
    parameter int unsigned       DIV_W   = BRG_DIV_W,
    parameter logic [DIV_W-1:0]  RST_DIV = DIV_W'(24)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [DIV_W-1:0] div,
    input  logic             sel_ext,
    input  logic             ext_pulse,
    output logic             tick
);

    localparam logic [DIV_W-1:0] RST_CNT = RST_DIV - DIV_W'(1);

    logic [DIV_W-1:0] cnt_q;
    logic [DIV_W-1:0] cnt_d;
    logic [DIV_W-1:0] div_q;
    logic [DIV_W-1:0] div_d;
    logic             tick_q;
    logic             tick_d;

    // A divisor change swallows the cycle's pulse and restarts the full period.
    always_comb begin
        cnt_d  = cnt_q;
        div_d  = div;
        tick_d = 1'b0;
        if (sel_ext) begin
            tick_d = ext_pulse;
            cnt_d  = RST_CNT;
        end else if (div != div_q) begin
            cnt_d = (div == '0) ? RST_CNT : div - DIV_W'(1);
        end else if (div == '0) begin
            cnt_d = RST_CNT;
        end else if (cnt_q == '0) begin
            cnt_d  = div - DIV_W'(1);
            tick_d = 1'b1;
        end else begin
            cnt_d = cnt_q - DIV_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q  <= RST_CNT;
            div_q  <= RST_DIV;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            div_q  <= div_d;
            tick_q <= tick_d;
        end
    end

    assign tick = tick_q;

endmodule

// File: rtl/brg_csr.sv
// MC68681 per-channel Clock Select Register and baud-rate generator feeding the UART 16x enables.
module brg_csr
    import brg_pkg::*;
#(
    parameter int unsigned CLK_HZ = BRG_CLK_HZ,
    parameter int unsigned DIV_W  = BRG_DIV_W
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cs,
    input  logic       rw,
    input  logic [7:0] data,
    input  logic       acr7,
    input  logic       ext_clk,
    output logic       rx_tick16,
    output logic       tx_tick16,
    output logic [7:0] csr_q
);

    localparam logic [DIV_W-1:0] RX_RST_DIV = DIV_W'(brg_divisor(BRG_CSR_RST[7:4], 1'b0, CLK_HZ));
    localparam logic [DIV_W-1:0] TX_RST_DIV = DIV_W'(brg_divisor(BRG_CSR_RST[3:0], 1'b0, CLK_HZ));

    logic [7:0]       csr_d;
    brg_csr_t         csr_s;
    logic [DIV_W-1:0] div_tbl [32];
    logic [DIV_W-1:0] rx_div;
    logic [DIV_W-1:0] tx_div;
    logic             ext_meta_q;
    logic             ext_sync_q;
    logic             ext_prev_q;
    logic             ext_pulse;

    // Divisors are elaboration-time constants indexed by {set, code}.
    for (genvar g = 0; g < 32; g++) begin : g_div_tbl
        localparam logic [DIV_W-1:0] DIV = DIV_W'(brg_divisor(4'(g % 16), 1'(g / 16), CLK_HZ));
        assign div_tbl[g] = DIV;
    end

    always_comb begin
        csr_d = csr_q;
        if (cs && !rw) begin
            csr_d = data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            csr_q <= BRG_CSR_RST;
        end else begin
            csr_q <= csr_d;
        end
    end

    // Two-flop synchroniser plus previous-value flop for rising-edge detect.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ext_meta_q <= 1'b0;
            ext_sync_q <= 1'b0;
            ext_prev_q <= 1'b0;
        end else begin
            ext_meta_q <= ext_clk;
            ext_sync_q <= ext_meta_q;
            ext_prev_q <= ext_sync_q;
        end
    end

    assign ext_pulse = ext_sync_q & ~ext_prev_q;
    assign csr_s     = brg_csr_t'(csr_q);
    assign rx_div    = div_tbl[{acr7, csr_s.rx}];
    assign tx_div    = div_tbl[{acr7, csr_s.tx}];

    brg_div #(
        .DIV_W   (DIV_W),
        .RST_DIV (RX_RST_DIV)
    ) u_rx_div (
        .clk       (clk),
        .rst       (rst),
        .div       (rx_div),
        .sel_ext   (csr_s.rx == BRG_EXT16),
        .ext_pulse (ext_pulse),
        .tick      (rx_tick16)
    );

    brg_div #(
        .DIV_W   (DIV_W),
        .RST_DIV (TX_RST_DIV)
    ) u_tx_div (
        .clk       (clk),
        .rst       (rst),
        .div       (tx_div),
        .sel_ext   (csr_s.tx == BRG_EXT16),
        .ext_pulse (ext_pulse),
        .tick      (tx_tick16)
    );

endmodule

// File: tb/tb_brg_csr.sv
// Bench for brg_csr: directed scenarios plus random CSR/ACR/ext traffic against a cycle-count model.
module tb_brg_csr;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cs = 1'b0;
    logic       rw = 1'b1;
    logic [7:0] data = 8'h00;
    logic       acr7 = 1'b0;
    logic       ext_clk = 1'b0;
    logic       rx_tick16;
    logic       tx_tick16;
    logic [7:0] csr_q;

    int errors = 0;
    int checks = 0;

    // Reference model state: edge count since reset, per-channel restart edge and active divisor.
    int         k;
    logic [7:0] csr_m;
    int         anchor [2];
    int         prev_div [2];
    logic       e1, e2, e3;
    int         first_p [2];
    int         last_p [2];
    int         gap_p [2];
    int         cnt_p [2];

    brg_csr dut (
        .clk       (clk),
        .rst       (rst),
        .cs        (cs),
        .rw        (rw),
        .data      (data),
        .acr7      (acr7),
        .ext_clk   (ext_clk),
        .rx_tick16 (rx_tick16),
        .tx_tick16 (tx_tick16),
        .csr_q     (csr_q)
    );

    always #5 clk = ~clk;

    function automatic int tb_div(input logic [3:0] code, input logic set);
        real b;
        case (code)
            4'h0: b = set ? 75.0 : 50.0;
            4'h1: b = 110.0;
            4'h2: b = 134.5;
            4'h3: b = set ? 150.0 : 200.0;
            4'h4: b = 300.0;
            4'h5: b = 600.0;
            4'h6: b = 1200.0;
            4'h7: b = set ? 2000.0 : 1050.0;
            4'h8: b = 2400.0;
            4'h9: b = 4800.0;
            4'hA: b = set ? 1800.0 : 7200.0;
            4'hB: b = 9600.0;
            4'hC: b = set ? 19200.0 : 38400.0;
            default: b = 0.0;
        endcase
        if (b == 0.0) return 0;
        return $rtoi(3686400.0 / (16.0 * b) + 0.5);
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h at edge %0d", tag, got, exp, k);
        end
    endtask

    task automatic model_reset();
        k        = 0;
        csr_m    = 8'hBB;
        e1 = 1'b0; e2 = 1'b0; e3 = 1'b0;
        for (int c = 0; c < 2; c++) begin
            anchor[c]   = 0;
            prev_div[c] = tb_div(4'hB, 1'b0);
            first_p[c]  = -1;
            last_p[c]   = -1;
            gap_p[c]    = -1;
            cnt_p[c]    = 0;
        end
    endtask

    // One clock edge: predict both ticks from the inputs present at the edge, then compare.
    task automatic step();
        logic [3:0] code;
        int         d;
        logic       exp_t [2];
        logic       obs_t [2];
        @(posedge clk);
        k++;
        for (int c = 0; c < 2; c++) begin
            code = (c == 0) ? csr_m[7:4] : csr_m[3:0];
            d    = tb_div(code, acr7);
            if (code == 4'hE) begin
                exp_t[c]    = e2 & ~e3;
                prev_div[c] = d;
            end else if (d != prev_div[c]) begin
                exp_t[c]    = 1'b0;
                anchor[c]   = k;
                prev_div[c] = d;
            end else if (d == 0) begin
                exp_t[c] = 1'b0;
            end else begin
                exp_t[c] = (k > anchor[c]) && (((k - anchor[c]) % d) == 0);
            end
        end
        if (cs && !rw) csr_m = data;
        e3 = e2; e2 = e1; e1 = ext_clk;
        #1;
        chk("rx_tick16", 32'(rx_tick16), 32'(exp_t[0]));
        chk("tx_tick16", 32'(tx_tick16), 32'(exp_t[1]));
        chk("csr_q", 32'(csr_q), 32'(csr_m));
        obs_t[0] = rx_tick16;
        obs_t[1] = tx_tick16;
        for (int c = 0; c < 2; c++) begin
            if (obs_t[c] === 1'b1) begin
                if (last_p[c] >= 0) gap_p[c] = k - last_p[c];
                else first_p[c] = k;
                last_p[c] = k;
                cnt_p[c]++;
            end
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic write_csr(input logic [7:0] v);
        cs = 1'b1; rw = 1'b0; data = v;
        step();
        cs = 1'b0; rw = 1'b1; data = 8'h00;
    endtask

    task automatic clear_stats();
        for (int c = 0; c < 2; c++) begin
            cnt_p[c] = 0;
        end
    endtask

    initial begin
        model_reset();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("reset_csr", 32'(csr_q), 32'h0000_00BB);
        chk("reset_rx", 32'(rx_tick16), 32'd0);
        chk("reset_tx", 32'(tx_tick16), 32'd0);

        // Default 9600/9600 after reset.
        run(100);
        chk("first_rx_edge", 32'(first_p[0]), 32'd24);
        chk("first_tx_edge", 32'(first_p[1]), 32'd24);
        chk("rx_period_9600", 32'(gap_p[0]), 32'd24);
        chk("tx_period_9600", 32'(gap_p[1]), 32'd24);

        // 38400 in set 1, then 19200 in set 2.
        write_csr(8'hCC);
        run(30);
        chk("rx_period_38400", 32'(gap_p[0]), 32'd6);
        chk("tx_period_38400", 32'(gap_p[1]), 32'd6);
        acr7 = 1'b1;
        run(40);
        chk("rx_period_19200", 32'(gap_p[0]), 32'd12);
        chk("tx_period_19200", 32'(gap_p[1]), 32'd12);

        // Rx from ext_clk at clk/10, Tx stays at 9600 with its phase intact.
        acr7 = 1'b0;
        write_csr(8'hBB);
        run(50);
        write_csr(8'hEB);
        clear_stats();
        for (int i = 0; i < 200; i++) begin
            ext_clk = ((i % 10) < 5);
            step();
        end
        ext_clk = 1'b0;
        chk("ext_rx_pulses", 32'(cnt_p[0]), 32'd20);
        chk("ext_tx_period", 32'(gap_p[1]), 32'd24);

        // Rewriting an identical code keeps the 24-cycle cadence.
        write_csr(8'hBB);
        run(50);
        write_csr(8'hBB);
        run(60);
        chk("rx_period_rewrite", 32'(gap_p[0]), 32'd24);
        chk("tx_period_rewrite", 32'(gap_p[1]), 32'd24);

        // Off codes, then a read cycle leaves the CSR alone.
        write_csr(8'hDF);
        clear_stats();
        run(10000);
        chk("off_rx_pulses", 32'(cnt_p[0]), 32'd0);
        chk("off_tx_pulses", 32'(cnt_p[1]), 32'd0);
        cs = 1'b1; rw = 1'b1; data = 8'h00;
        step();
        cs = 1'b0;
        chk("read_no_write", 32'(csr_q), 32'h0000_00DF);

        // Asynchronous reset in the middle of a count.
        write_csr(8'hB4);
        run(12);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_csr", 32'(csr_q), 32'h0000_00BB);
        chk("async_rst_rx", 32'(rx_tick16), 32'd0);
        chk("async_rst_tx", 32'(tx_tick16), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        run(30);
        chk("post_rst_first_rx", 32'(first_p[0]), 32'd24);
        chk("post_rst_first_tx", 32'(first_p[1]), 32'd24);

        // Random CSR writes, ACR toggles and ext_clk activity.
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 39) == 0) begin
                if ($urandom_range(0, 1) == 0) data = 8'($urandom_range(0, 255));
                else data = {4'($urandom_range(8, 15)), 4'($urandom_range(8, 15))};
                cs = 1'b1;
                rw = ($urandom_range(0, 4) == 0);
            end else begin
                cs = 1'b0;
                rw = 1'b1;
            end
            if ($urandom_range(0, 199) == 0) acr7 = ~acr7;
            if ($urandom_range(0, 3) == 0) ext_clk = ~ext_clk;
            step();
        end
        cs = 1'b0;
        rw = 1'b1;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
